fetch_buffer: RTL and testbench

Decoupling queue between the instruction fetch stage (PC register, +4 adder, instruction memory) and the decode stage. Each cycle it captures one fetched {pc, instruction} pair and presents the oldest pair to decode through a valid/ready handshake. Decode can stall without losing fetched words. A redirect (branch/jump) flushes all queued words.

---
 rtl/fetch_buffer_pkg.sv | 24 ++
 rtl/fetch_buffer_mem.sv | 33 +++
 rtl/fetch_buffer.sv | 111 +++++++++++
 tb/tb_fetch_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared constants and the stored-entry layout for the fetch-to-decode queue.
package fetch_buffer_pkg;

  localparam int          DEFAULT_DEPTH = 4;
  localparam logic [31:0] RESET_PC      = 32'h0040_0020;
  localparam logic [31:0] WORD_BYTES    = 32'd4;
  localparam int          ENTRY_W       = 65;

  // Layout is {misaligned, pc, instr}, matching the storage array width.
  typedef struct packed {
    logic        misaligned;
    logic [31:0] pc;
    logic [31:0] instr;
  } fb_entry_t;

  function automatic fb_entry_t make_entry(input logic [31:0] pc, input logic [31:0] instr);
    fb_entry_t e;
    e.misaligned = |pc[1:0];
    e.pc         = pc;
    e.instr      = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_buffer_mem.sv
// DEPTH x 65-bit register array: one synchronous write port, one asynchronous read port.
module fetch_buffer_mem
  import fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [PTR_W-1:0]   rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Contents are masked by the occupancy count, so the array needs no reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode decoupling queue: circular buffer with first-word fall-through and flush on redirect.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic             out_misaligned,
  output logic [PTR_W:0]   count,
  output logic [31:0]      issued_total
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [31:0]        issued_q, issued_d;
  logic               not_empty;
  logic               push;
  logic               pop;
  fb_entry_t          wr_entry;
  fb_entry_t          rd_entry;
  logic [ENTRY_W-1:0] rd_raw;

  // Handshakes look only at registered occupancy and flush, never at the partner's valid/ready.
  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != FULL_COUNT) && !flush;
  assign out_valid = not_empty && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wr_entry  = make_entry(in_pc, in_instr);

  fetch_buffer_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_raw)
  );

  assign rd_entry = fb_entry_t'(rd_raw);

  always_comb begin
    out_pc         = '0;
    out_instr      = '0;
    out_misaligned = 1'b0;
    if (not_empty) begin
      out_pc         = rd_entry.pc;
      out_instr      = rd_entry.instr;
      out_misaligned = rd_entry.misaligned;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    issued_d = issued_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        issued_d = issued_q + 32'd1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      issued_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      issued_q <= issued_d;
    end
  end

  assign count        = count_q;
  assign issued_total = issued_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed vector table, corner sequences and a queue-based random model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clock;
  logic             resetn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_misaligned;
  logic [PTR_W:0]   count;
  logic [31:0]      issued_total;

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misaligned (out_misaligned),
    .count          (count),
    .issued_total   (issued_total)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ref_entry_t;

  ref_entry_t  ref_q[$];
  int unsigned ref_issued;
  int          checks;
  int          errors;

  typedef struct {
    logic        rstn;
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    int          exp_count;
    int          exp_issued;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle's inputs, compares against the queue model, then advances the model.
  task automatic applyStimulus(input logic rstn, input logic fl, input logic iv, input logic ordy,
                               input logic [31:0] pc, input logic [31:0] instr, output logic pushed);
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_mis;
    ref_entry_t  dropped;
    resetn    = rstn;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_pc     = pc;
    in_instr  = instr;
    #1;
    exp_ir    = !fl && (ref_q.size() < DEPTH);
    exp_ov    = !fl && (ref_q.size() > 0);
    exp_pc    = 32'h0;
    exp_instr = 32'h0;
    exp_mis   = 1'b0;
    if (ref_q.size() > 0) begin
      exp_pc    = ref_q[0].pc;
      exp_instr = ref_q[0].instr;
      exp_mis   = (exp_pc[1:0] != 2'b00);
    end
    checkOutput("model_in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
    checkOutput("model_out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    checkOutput("model_out_pc", out_pc, exp_pc);
    checkOutput("model_out_instr", out_instr, exp_instr);
    checkOutput("model_out_misaligned", {31'b0, out_misaligned}, {31'b0, exp_mis});
    checkOutput("model_count", 32'(count), 32'(ref_q.size()));
    checkOutput("model_issued_total", issued_total, ref_issued);
    pushed = 1'b0;
    if (!rstn) begin
      ref_q.delete();
      ref_issued = 0;
    end else if (fl) begin
      ref_q.delete();
    end else begin
      if (exp_ov && ordy) begin
        dropped = ref_q.pop_front();
        ref_issued++;
      end
      if (iv && exp_ir) begin
        ref_q.push_back('{pc: pc, instr: instr});
        pushed = 1'b1;
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic        pushed;
    logic [31:0] next_pc;
    logic [31:0] rnd_pc;
    checks     = 0;
    errors     = 0;
    ref_issued = 0;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, RESET_PC,       32'h2008_0005, 1'b1, 1'b0, 32'h0,     32'h0,         0, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, RESET_PC,       32'h2008_0005, 1'b1, 1'b0, 32'h0,     32'h0,         0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0020,  32'h2008_0005, 1'b1, 1'b0, 32'h0,     32'h0,         0, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0024,  32'h2009_0003, 1'b1, 1'b1, 32'h0040_0020, 32'h2008_0005, 1, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0028,  32'h0109_5020, 1'b1, 1'b1, 32'h0040_0020, 32'h2008_0005, 2, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_002C,  32'h0000_0000, 1'b1, 1'b1, 32'h0040_0020, 32'h2008_0005, 3, 0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0030,  32'h1234_5678, 1'b0, 1'b1, 32'h0040_0020, 32'h2008_0005, 4, 0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0030,  32'h1234_5678, 1'b0, 1'b1, 32'h0040_0020, 32'h2008_0005, 4, 0};

    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_pc     = 32'h0;
    in_instr  = 32'h0;
    nextCycle();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].pc, vecs[i].instr, pushed);
      checkOutput($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_in_ready});
      checkOutput($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_out_valid});
      checkOutput($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d_out_instr", i), out_instr, vecs[i].exp_instr);
      checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d_issued", i), issued_total, 32'(vecs[i].exp_issued));
      nextCycle();
    end

    next_pc = RESET_PC + 4 * WORD_BYTES;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, next_pc, next_pc ^ 32'hA5A5_0000, pushed);
      checkOutput("drain_out_pc", out_pc, RESET_PC + WORD_BYTES * 32'(k));
      if (pushed) next_pc = next_pc + WORD_BYTES;
      nextCycle();
    end
    checkOutput("drain_issued", issued_total, 32'd12);
    checkOutput("drain_count", 32'(count), 32'd3);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, next_pc, 32'h0, pushed);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, next_pc, next_pc ^ 32'h5A5A_0000, pushed);
      checkOutput("pushpop_count", 32'(count), 32'd2);
      checkOutput("pushpop_out_pc", out_pc, 32'h0040_0054 + WORD_BYTES * 32'(k));
      if (pushed) next_pc = next_pc + WORD_BYTES;
      nextCycle();
    end

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, next_pc, 32'h1111_2222, pushed);
    nextCycle();
    checkOutput("preflush_count", 32'(count), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0200, 32'h3333_4444, pushed);
    checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
    nextCycle();
    checkOutput("postflush_count", 32'(count), 32'd0);
    checkOutput("postflush_issued", issued_total, 32'd17);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0100, 32'hDEAD_0100, pushed);
    nextCycle();
    checkOutput("redirect_out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("redirect_out_pc", out_pc, 32'h0040_0100);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0022, 32'hBEEF_0022, pushed);
    nextCycle();
    checkOutput("misaligned_tag", {31'b0, out_misaligned}, 32'd1);
    checkOutput("misaligned_pc", out_pc, 32'h0040_0022);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0024, 32'hBEEF_0024, pushed);
    nextCycle();
    checkOutput("aligned_tag", {31'b0, out_misaligned}, 32'd0);
    checkOutput("aligned_pc", out_pc, 32'h0040_0024);

    for (int r = 0; r < 600; r++) begin
      rnd_pc = $urandom;
      if ($urandom_range(0, 3) != 0) rnd_pc[1:0] = 2'b00;
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    rnd_pc, $urandom, pushed);
      nextCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
